// File: rtl/up_down_counter_p.sv
// Up/down counter with programmable upper bound, synchronous load,
// selectable wrap or saturate behaviour at the bounds, and one-cycle
// wrap/sat event pulses.
module up_down_counter_p #(
   parameter int WIDTH    = 4,
   parameter int SATURATE = 0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             en,
   input  logic             s,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] max_val,
   output logic [WIDTH-1:0] y,
   output logic             at_max,
   output logic             at_min,
   output logic             wrap,
   output logic             sat
);

   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
   localparam logic [WIDTH-1:0] ZERO = '0;
   localparam bit               HOLD_AT_BOUND = (SATURATE != 0);

   logic [WIDTH-1:0] r_y;
   logic             r_wrap;
   logic             r_sat;

   logic [WIDTH-1:0] w_y_next;
   logic             w_wrap_next;
   logic             w_sat_next;
   logic             w_at_top;
   logic             w_at_bottom;
   logic             w_out_of_range;

   assign w_at_top       = (r_y == max_val);
   assign w_at_bottom    = (r_y == ZERO);
   assign w_out_of_range = (r_y > max_val);

   // Next-state selection: load beats enable, enable beats hold.
   always_comb begin
      w_y_next    = r_y;
      w_wrap_next = 1'b0;
      w_sat_next  = 1'b0;
      if (load) begin
         // Loaded values above the bound are clamped to the bound.
         w_y_next = (load_val > max_val) ? max_val : load_val;
      end else if (en) begin
         if (w_out_of_range) begin
            // Bound was lowered below the count: re-enter the range.
            if (HOLD_AT_BOUND) begin
               w_y_next   = max_val;
               w_sat_next = 1'b1;
            end else begin
               w_y_next    = s ? ZERO : max_val;
               w_wrap_next = 1'b1;
            end
         end else if (s) begin
            if (w_at_top) begin
               if (HOLD_AT_BOUND) begin
                  w_sat_next = 1'b1;
               end else begin
                  w_y_next    = ZERO;
                  w_wrap_next = 1'b1;
               end
            end else begin
               w_y_next = r_y + ONE;
            end
         end else begin
            if (w_at_bottom) begin
               if (HOLD_AT_BOUND) begin
                  w_sat_next = 1'b1;
               end else begin
                  w_y_next    = max_val;
                  w_wrap_next = 1'b1;
               end
            end else begin
               w_y_next = r_y - ONE;
            end
         end
      end
   end

   // Count and event-pulse registers; reset clears them immediately.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_y    <= ZERO;
         r_wrap <= 1'b0;
         r_sat  <= 1'b0;
      end else begin
         r_y    <= w_y_next;
         r_wrap <= w_wrap_next;
         r_sat  <= w_sat_next;
      end
   end

   assign y      = r_y;
   assign wrap   = r_wrap;
   assign sat    = r_sat;
   assign at_max = w_at_top;
   assign at_min = w_at_bottom;

endmodule

// File: tb/tb_up_down_counter_p.sv
// Directed bench: one wrapping and one saturating counter share the same
// stimulus; a vector table covers the single-step behaviour and a
// hand-written sequence covers asynchronous reset mid-pulse.
module tb_up_down_counter_p;

   typedef struct {
      bit         ld;
      logic [3:0] lv;
      bit         en;
      bit         s;
      logic [3:0] mx;
      logic [3:0] y0;
      bit         w0;
      bit         s0;
      logic [3:0] y1;
      bit         w1;
      bit         s1;
   } vec_t;

   logic       clock = 1'b0;
   logic       reset;
   logic       en, s, load;
   logic [3:0] load_val, max_val;
   logic [3:0] y0, y1;
   logic       at_max0, at_min0, wrap0, sat0;
   logic       at_max1, at_min1, wrap1, sat1;

   int checks = 0;
   int errors = 0;
   vec_t vecs[$];

   always #5 clock = ~clock;

   up_down_counter_p #(.WIDTH(4), .SATURATE(0)) dut0 (
      .clock(clock), .reset(reset), .en(en), .s(s), .load(load),
      .load_val(load_val), .max_val(max_val), .y(y0),
      .at_max(at_max0), .at_min(at_min0), .wrap(wrap0), .sat(sat0));

   up_down_counter_p #(.WIDTH(4), .SATURATE(1)) dut1 (
      .clock(clock), .reset(reset), .en(en), .s(s), .load(load),
      .load_val(load_val), .max_val(max_val), .y(y1),
      .at_max(at_max1), .at_min(at_min1), .wrap(wrap1), .sat(sat1));

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic add(input bit ld, input int lv, input bit e, input bit dir,
                      input int mx, input int ey0, input bit ew0, input bit es0,
                      input int ey1, input bit ew1, input bit es1);
      vec_t v;
      v.ld = ld; v.lv = 4'(lv); v.en = e; v.s = dir; v.mx = 4'(mx);
      v.y0 = 4'(ey0); v.w0 = ew0; v.s0 = es0;
      v.y1 = 4'(ey1); v.w1 = ew1; v.s1 = es1;
      vecs.push_back(v);
   endtask

   initial begin
      reset = 1'b0; en = 1'b0; s = 1'b1; load = 1'b0;
      load_val = 4'd0; max_val = 4'd9;

      // Count up from reset, max 9: wrap vs saturate at the top.
      for (int k = 1; k <= 9; k++) add(0, 0, 1, 1, 9, k, 0, 0, k, 0, 0);
      add(0, 0, 1, 1, 9, 0, 1, 0, 9, 0, 1);
      add(0, 0, 1, 1, 9, 1, 0, 0, 9, 0, 1);
      add(0, 0, 1, 1, 9, 2, 0, 0, 9, 0, 1);
      // Hold, then load (beats enable), then count down through 0.
      add(0, 0, 0, 1, 9, 2, 0, 0, 9, 0, 0);
      add(1, 0, 1, 1, 9, 0, 0, 0, 0, 0, 0);
      add(0, 0, 1, 0, 9, 9, 1, 0, 0, 0, 1);
      add(0, 0, 1, 0, 9, 8, 0, 0, 0, 0, 1);
      add(0, 0, 1, 0, 9, 7, 0, 0, 0, 0, 1);
      // Clamped load, then step past the top.
      add(1, 12, 1, 1, 9, 9, 0, 0, 9, 0, 0);
      add(0, 0, 1, 1, 9, 0, 1, 0, 9, 0, 1);
      // Bound lowered below the count, then a normal step.
      add(1, 7, 0, 0, 9, 7, 0, 0, 7, 0, 0);
      add(0, 0, 1, 0, 3, 3, 1, 0, 3, 0, 1);
      add(0, 0, 1, 0, 3, 2, 0, 0, 2, 0, 0);
      // Full binary range.
      add(1, 15, 0, 1, 15, 15, 0, 0, 15, 0, 0);
      add(0, 0, 1, 1, 15, 0, 1, 0, 15, 0, 1);
      // max_val == 0.
      add(0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 1);
      add(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      // Direction change on consecutive edges.
      add(0, 0, 1, 1, 9, 1, 0, 0, 1, 0, 0);
      add(0, 0, 1, 0, 9, 0, 0, 0, 0, 0, 0);

      // Reset state, including an edge while held.
      en = 1'b1;
      @(posedge clock); #1;
      chk("rst_y0", y0, 0);
      chk("rst_y1", y1, 0);
      chk("rst_wrap0", wrap0, 0);
      chk("rst_sat1", sat1, 0);
      chk("rst_at_min0", at_min0, 1);
      chk("rst_at_max0", at_max0, 0);
      @(negedge clock);
      en = 1'b0;
      reset = 1'b1;

      foreach (vecs[i]) begin
         @(negedge clock);
         load = vecs[i].ld; load_val = vecs[i].lv; en = vecs[i].en;
         s = vecs[i].s; max_val = vecs[i].mx;
         @(posedge clock); #1;
         chk($sformatf("v%0d_y0", i), y0, vecs[i].y0);
         chk($sformatf("v%0d_wrap0", i), wrap0, vecs[i].w0);
         chk($sformatf("v%0d_sat0", i), sat0, vecs[i].s0);
         chk($sformatf("v%0d_y1", i), y1, vecs[i].y1);
         chk($sformatf("v%0d_wrap1", i), wrap1, vecs[i].w1);
         chk($sformatf("v%0d_sat1", i), sat1, vecs[i].s1);
         chk($sformatf("v%0d_at_max0", i), at_max0, int'(vecs[i].y0 == vecs[i].mx));
         chk($sformatf("v%0d_at_min0", i), at_min0, int'(vecs[i].y0 == 4'd0));
         chk($sformatf("v%0d_at_max1", i), at_max1, int'(vecs[i].y1 == vecs[i].mx));
         chk($sformatf("v%0d_at_min1", i), at_min1, int'(vecs[i].y1 == 4'd0));
      end

      // Asynchronous reset while y=6 and wrap=1.
      @(negedge clock);
      load = 1'b1; load_val = 4'd0; en = 1'b0; max_val = 4'd6;
      @(negedge clock);
      load = 1'b0; en = 1'b1; s = 1'b0;
      @(posedge clock); #1;
      chk("pre_rst_y0", y0, 6);
      chk("pre_rst_wrap0", wrap0, 1);
      chk("pre_rst_sat1", sat1, 1);
      #2 reset = 1'b0;
      #1;
      chk("async_y0", y0, 0);
      chk("async_wrap0", wrap0, 0);
      chk("async_sat1", sat1, 0);
      chk("async_at_min0", at_min0, 1);
      @(posedge clock); #1;
      chk("held_y0", y0, 0);
      @(negedge clock);
      reset = 1'b1; s = 1'b1;
      @(posedge clock); #1;
      chk("resume_y0", y0, 1);
      chk("resume_wrap0", wrap0, 0);
      chk("resume_y1", y1, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/up_down_counter_p.md
UP_DOWN_COUNTER_P -- requirements
Module: up_down_counter_p

Interface
REQ-001 Parameter: WIDTH, default 4, counter width in bits (legal 2..32).
REQ-002 Parameter: SATURATE, default 0; 0 = wrap at bounds, 1 = hold at bounds.
REQ-003 Port: clock  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset; assertion (0) clears state immediately, independent of clock.
REQ-005 Port: en  input  1  count enable; 1 = take one step this cycle.
REQ-006 Port: s  input  1  direction; 1 = up, 0 = down.
REQ-007 Port: load  input  1  synchronous load strobe.
REQ-008 Port: load_val  input  WIDTH  value applied on load.
REQ-009 Port: max_val  input  WIDTH  programmable upper bound; count range is 0..max_val inclusive.
REQ-010 Port: y  output  WIDTH  registered count value.
REQ-011 Port: at_max  output  1  combinational, 1 when y == max_val.
REQ-012 Port: at_min  output  1  combinational, 1 when y == 0.
REQ-013 Port: wrap  output  1  registered one-cycle pulse, 1 in the cycle after a wrap step.
REQ-014 Port: sat  output  1  registered one-cycle pulse, 1 in the cycle after a step blocked by saturation.

Function
REQ-015 Priority per clock edge: load > en > hold; with load=0 and en=0, y, wrap and sat keep y and drive 0 on the flags.
REQ-016 Load: y <= min(load_val, max_val); wrap <= 0, sat <= 0; en and s ignored in that cycle.
REQ-017 Up step (en=1, s=1, y < max_val): y <= y+1; wrap <= 0, sat <= 0.
REQ-018 Down step (en=1, s=0, 0 < y <= max_val): y <= y-1; wrap <= 0, sat <= 0.
REQ-019 Up at bound (y == max_val), SATURATE=0: y <= 0, wrap <= 1.
REQ-020 Down at bound (y == 0), SATURATE=0: y <= max_val, wrap <= 1.
REQ-021 SATURATE=1, step at bound in the count direction: y holds; sat <= 1; wrap stays 0.
REQ-022 Out-of-range (y > max_val after max_val is lowered), enabled step:
  - SATURATE=0: y <= 0 for up, y <= max_val for down; wrap <= 1.
  - SATURATE=1: y <= max_val in either direction; sat <= 1.
REQ-023 max_val == 0: y stays 0 on every step; wrap (SATURATE=0) or sat (SATURATE=1) pulses on each enabled step.
REQ-024 Direction change takes effect on the same edge it is sampled; no dead cycle, no extra step.
REQ-025 Arithmetic is modulo 2^WIDTH internally; no carry escapes WIDTH; max_val = 2^WIDTH-1 gives a full binary range.
REQ-026 wrap and sat are never both 1; each is high for exactly one cycle per event and is re-evaluated every edge.
REQ-027 at_max and at_min are both 1 only when max_val == 0.

Reset
REQ-028 reset = 0 forces y = 0, wrap = 0, sat = 0 asynchronously, including mid-count or mid-pulse.
REQ-029 Release of reset is synchronised by the user; the first edge with reset = 1 applies normal REQ-015 priority.
REQ-030 at_min = 1 throughout reset; at_max reflects max_val == 0.

Verification (WIDTH=4)
REQ-031 SATURATE=0, max_val=9, s=1, en=1 for 12 cycles from reset -> y 1..9, 0, 1, 2; wrap high exactly once, in the cycle y shows 0.
REQ-032 SATURATE=0, max_val=9, s=0, en=1 from y=0 -> y = 9 with wrap pulse, then 8, 7; at_min high only while y=0.
REQ-033 SATURATE=1, max_val=5, count up 8 steps -> y sticks at 5; sat pulses on steps 6, 7, 8; wrap never asserts.
REQ-034 load=1, load_val=12, max_val=9 with en=1 -> y = 9 (clamped), no flag; next up step -> y = 0, wrap = 1.
REQ-035 y=7, max_val lowered to 3, en=1, s=0 -> y = 3 with wrap = 1 (SATURATE=0); repeat with SATURATE=1 -> y = 3 with sat = 1.
REQ-036 reset driven low between clock edges while y=6 and wrap=1 -> y = 0 and wrap = 0 before the next edge; count resumes from 0 after release.
